// File: rtl/wb_slave_mux.sv
// Wishbone B4 classic interconnect stage: one master, three slaves.
// Locks the decoded slave for a whole bus cycle and flags unmapped or unresponsive accesses.
module wb_slave_mux #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  input  logic        acmp0,
  input  logic        acmp1,
  input  logic        acmp2,
  output logic [2:0]  slv_cyc_o,
  output logic [2:0]  slv_stb_o,
  input  logic [2:0]  slv_ack_i,
  input  logic [31:0] slv0_dat_i,
  input  logic [31:0] slv1_dat_i,
  input  logic [31:0] slv2_dat_i,
  output logic [31:0] slv_adr_o,
  output logic [31:0] slv_dat_o,
  output logic        slv_we_o,
  output logic [3:0]  slv_sel_o,
  output logic        fault_o
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_ERR,
    ST_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_q, err_d;
  logic             fault_q, fault_d;
  logic             ack_sel;

  assign slv_adr_o = adr_i;
  assign slv_dat_o = dat_i;
  assign slv_we_o  = we_i;
  assign slv_sel_o = sel_i;

  // sel_q is only non-zero in ACTIVE, so it alone gates every slave-facing strobe.
  assign slv_cyc_o = sel_q & {3{cyc_i}};
  assign slv_stb_o = sel_q & {3{cyc_i & stb_i}};
  assign ack_sel   = |(slv_ack_i & sel_q);
  assign ack_o     = ack_sel & cyc_i;
  assign dat_o     = ({32{sel_q[0]}} & slv0_dat_i)
                   | ({32{sel_q[1]}} & slv1_dat_i)
                   | ({32{sel_q[2]}} & slv2_dat_i);
  assign err_o     = err_q;
  assign fault_o   = fault_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          if (acmp0)      sel_d = 3'b001;
          else if (acmp1) sel_d = 3'b010;
          else if (acmp2) sel_d = 3'b100;
          else            sel_d = 3'b000;
          state_d = (sel_d != 3'b000) ? ST_ACTIVE : ST_ERR;
        end
      end
      ST_ACTIVE: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          sel_d   = 3'b000;
        end else if (stb_i && !ack_sel) begin
          // A selected ack in the cycle the count would hit TIMEOUT takes precedence.
          if (cnt_inc == TIMEOUT_C) begin
            state_d = ST_ERR;
            sel_d   = 3'b000;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_ERR: begin
        sel_d   = 3'b000;
        state_d = cyc_i ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!cyc_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'b000;
      end
    endcase
    err_d   = (state_d == ST_ERR);
    fault_d = fault_q | err_d;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'b000;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

endmodule
